// File: rtl/hack_run_controller.sv
// Run sequencer for the Hack Computer: pulses its reset, gates its run enable,
// counts executed cycles, detects the terminal jump loop and snapshots PC/A/D.
module hack_run_controller #(
  parameter int PC_W         = 16,
  parameter int DATA_W       = 16,
  parameter int CYCLE_W      = 32,
  parameter int RESET_CYCLES = 3,
  parameter int HALT_REPEAT  = 4,
  parameter int MAX_CYCLES   = 1800
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [PC_W-1:0]    pc,
  input  logic [DATA_W-1:0]  a_in,
  input  logic [DATA_W-1:0]  d_in,
  output logic               cpu_reset,
  output logic               cpu_run,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status,
  output logic [CYCLE_W-1:0] cycles,
  output logic [PC_W-1:0]    final_pc,
  output logic [DATA_W-1:0]  final_a,
  output logic [DATA_W-1:0]  final_d
);

  localparam int SW = $clog2(HALT_REPEAT + 1);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [SW:0] HALT_LIM = (SW+1)'(HALT_REPEAT);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic [RW-1:0]       rcnt_q;
  logic [PC_W-1:0]     hist1_q, hist2_q;
  logic                h1v_q, h2v_q;
  logic [SW-1:0]       streak_q, streak_d;
  logic                cpu_reset_q, cpu_run_q, busy_q, done_q;
  logic [1:0]          status_q;
  logic [CYCLE_W-1:0]  cycles_q, cycles_d;
  logic [PC_W-1:0]     final_pc_q;
  logic [DATA_W-1:0]   final_a_q, final_d_q;
  logic [SW:0]         streak_inc;
  logic                hit, halt, tmo;

  // Termination is judged on the post-increment cycle count and streak.
  always_comb begin
    cycles_d   = (cycles_q == '1) ? cycles_q : cycles_q + CYCLE_W'(1);
    hit        = (h1v_q && (pc == hist1_q)) || (h2v_q && (pc == hist2_q));
    streak_inc = {1'b0, streak_q} + (SW+1)'(1);
    halt       = hit && (streak_inc >= HALT_LIM);
    streak_d   = hit ? streak_inc[SW-1:0] : '0;
    tmo        = (MAX_CYCLES != 0) && (cycles_d == CYCLE_W'(MAX_CYCLES));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rcnt_q      <= '0;
      hist1_q     <= '0;
      hist2_q     <= '0;
      h1v_q       <= 1'b0;
      h2v_q       <= 1'b0;
      streak_q    <= '0;
      cpu_reset_q <= 1'b1;
      cpu_run_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 2'b00;
      cycles_q    <= '0;
      final_pc_q  <= '0;
      final_a_q   <= '0;
      final_d_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= S_RESET;
            busy_q   <= 1'b1;
            cycles_q <= '0;
            status_q <= 2'b00;
            h1v_q    <= 1'b0;
            h2v_q    <= 1'b0;
            streak_q <= '0;
            rcnt_q   <= RW'(RESET_CYCLES - 1);
          end
        end
        S_RESET: begin
          if (rcnt_q == '0) begin
            state_q     <= S_RUN;
            cpu_reset_q <= 1'b0;
            cpu_run_q   <= 1'b1;
          end else begin
            rcnt_q <= rcnt_q - RW'(1);
          end
        end
        S_RUN: begin
          cycles_q <= cycles_d;
          streak_q <= streak_d;
          hist2_q  <= hist1_q;
          h2v_q    <= h1v_q;
          hist1_q  <= pc;
          h1v_q    <= 1'b1;
          if (stop || halt || tmo) begin
            status_q    <= stop ? 2'b11 : (halt ? 2'b01 : 2'b10);
            final_pc_q  <= pc;
            final_a_q   <= a_in;
            final_d_q   <= d_in;
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            cpu_run_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_reset = cpu_reset_q;
  assign cpu_run   = cpu_run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign status    = status_q;
  assign cycles    = cycles_q;
  assign final_pc  = final_pc_q;
  assign final_a   = final_a_q;
  assign final_d   = final_d_q;

endmodule

// File: tb/tb_hack_run_controller.sv
// Bench for hack_run_controller: two instances (default and HALT_REPEAT=2/MAX_CYCLES=20)
// driven by directed vector tables, a mid-run reset sequence and random runs.
module tb_hack_run_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start_s[2], stop_s[2];
  logic [15:0] pc_s[2], a_s[2], d_s[2];
  logic        cpu_reset_s[2], cpu_run_s[2], busy_s[2], done_s[2];
  logic [1:0]  status_s[2];
  logic [31:0] cycles_s[2];
  logic [15:0] fpc_s[2], fa_s[2], fd_s[2];

  int hr[2] = '{4, 2};
  int mc[2] = '{1800, 20};

  int checks = 0;
  int errors = 0;
  int pcq[$];

  hack_run_controller u_dflt (
    .clock(clock), .reset(reset), .start(start_s[0]), .stop(stop_s[0]),
    .pc(pc_s[0]), .a_in(a_s[0]), .d_in(d_s[0]),
    .cpu_reset(cpu_reset_s[0]), .cpu_run(cpu_run_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .status(status_s[0]), .cycles(cycles_s[0]),
    .final_pc(fpc_s[0]), .final_a(fa_s[0]), .final_d(fd_s[0])
  );

  hack_run_controller #(.HALT_REPEAT(2), .MAX_CYCLES(20)) u_short (
    .clock(clock), .reset(reset), .start(start_s[1]), .stop(stop_s[1]),
    .pc(pc_s[1]), .a_in(a_s[1]), .d_in(d_s[1]),
    .cpu_reset(cpu_reset_s[1]), .cpu_run(cpu_run_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .status(status_s[1]), .cycles(cycles_s[1]),
    .final_pc(fpc_s[1]), .final_a(fa_s[1]), .final_d(fd_s[1])
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic bit is_hit(input int tr[$], input int j);
    return (j >= 1 && tr[j] == tr[j-1]) || (j >= 2 && tr[j] == tr[j-2]);
  endfunction

  task automatic chk_reset_vals(input int u, input string nm);
    chk({nm, ".cpu_reset"}, cpu_reset_s[u], 1);
    chk({nm, ".cpu_run"},   cpu_run_s[u],   0);
    chk({nm, ".busy"},      busy_s[u],      0);
    chk({nm, ".done"},      done_s[u],      0);
    chk({nm, ".status"},    status_s[u],    0);
    chk({nm, ".cycles"},    cycles_s[u],    0);
    chk({nm, ".final_pc"},  fpc_s[u],       0);
  endtask

  task automatic fill_pat(input int pat);
    pcq.delete();
    case (pat)
      0: begin
        for (int i = 0; i < 10; i++) pcq.push_back(i);
        for (int i = 0; i < 3; i++) begin pcq.push_back(10); pcq.push_back(11); end
      end
      1: for (int i = 0; i < 40; i++) pcq.push_back(i);
      default: begin
        pcq.push_back(3);
        for (int i = 0; i < 5; i++) pcq.push_back(4);
      end
    endcase
  endtask

  task automatic start_and_reset_phase(input int u, input string nm);
    start_s[u] = 1'b1;
    step();
    start_s[u] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      chk({nm, ".rst_busy"},  busy_s[u],      1);
      chk({nm, ".rst_cpu"},   cpu_reset_s[u], 1);
      chk({nm, ".rst_run"},   cpu_run_s[u],   0);
      start_s[u] = 1'($urandom_range(0, 1));
      stop_s[u]  = 1'($urandom_range(0, 1));
      step();
    end
    start_s[u] = 1'b0;
    stop_s[u]  = 1'b0;
    chk({nm, ".run_en"},  cpu_run_s[u],   1);
    chk({nm, ".run_rst"}, cpu_reset_s[u], 0);
  endtask

  task automatic do_run(input int u, input int stop_at, input string nm,
                        output int rst, output int rcyc, output int rpc);
    int tr[$];
    int k, streak, st_m, fa, fd;
    bit term, stp;
    start_and_reset_phase(u, nm);
    term = 0; k = 0; st_m = 0;
    while (!term && k < pcq.size()) begin
      stp = (k + 1 == stop_at);
      pc_s[u] = 16'(pcq[k]);
      a_s[u] = 16'($urandom);
      d_s[u] = 16'($urandom);
      stop_s[u] = stp;
      start_s[u] = 1'($urandom_range(0, 1));
      fa = int'(a_s[u]);
      fd = int'(d_s[u]);
      tr.push_back(pcq[k]);
      k++;
      streak = 0;
      for (int j = k - 1; j >= 0; j--) begin
        if (is_hit(tr, j)) streak++;
        else break;
      end
      st_m = stp ? 3 : (streak >= hr[u]) ? 1 : (mc[u] != 0 && k == mc[u]) ? 2 : 0;
      step();
      chk({nm, ".cycles"}, cycles_s[u], k);
      chk({nm, ".done"}, done_s[u], (st_m != 0));
      if (st_m != 0) begin
        term = 1;
        chk({nm, ".status"},   status_s[u],  st_m);
        chk({nm, ".final_pc"}, fpc_s[u],     pcq[k-1]);
        chk({nm, ".final_a"},  fa_s[u],      fa);
        chk({nm, ".final_d"},  fd_s[u],      fd);
        chk({nm, ".busy_dn"},  busy_s[u],    0);
        chk({nm, ".run_dn"},   cpu_run_s[u], 0);
      end else begin
        chk({nm, ".run_on"}, cpu_run_s[u], 1);
      end
    end
    stop_s[u] = 1'b0;
    chk({nm, ".terminated"}, term, 1);
    start_s[u] = 1'b1;
    step();
    chk({nm, ".done_once"}, done_s[u],      0);
    chk({nm, ".idle_rst"},  cpu_reset_s[u], 1);
    chk({nm, ".idle_run"},  cpu_run_s[u],   0);
    chk({nm, ".st_hold"},   status_s[u],    st_m);
    start_s[u] = 1'b0;
    step();
    chk({nm, ".done_start_ign"}, busy_s[u], 0);
    chk({nm, ".pc_hold"}, fpc_s[u], (k > 0) ? pcq[k-1] : 0);
    rst = st_m;
    rcyc = k;
    rpc = (k > 0) ? pcq[k-1] : 0;
  endtask

  typedef struct {
    int    u;
    int    pat;
    int    stop_at;
    int    exp_st;
    int    exp_cyc;
    int    exp_pc;
    string nm;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int st, cy, fp;

    vecs[0] = '{0, 0, 0,  1, 16, 11, "halt"};
    vecs[1] = '{1, 1, 0,  2, 20, 19, "timeout"};
    vecs[2] = '{0, 1, 5,  3, 5,  4,  "abort"};
    vecs[3] = '{0, 0, 16, 3, 16, 11, "stop_halt"};
    vecs[4] = '{1, 2, 0,  1, 4,  4,  "period1"};
    vecs[5] = '{1, 0, 0,  1, 14, 11, "halt_hr2"};

    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0; stop_s[u] = 1'b0;
      pc_s[u] = '0; a_s[u] = '0; d_s[u] = '0;
    end
    #1 reset = 1'b0;
    #1;
    chk_reset_vals(0, "por0");
    chk_reset_vals(1, "por1");
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      fill_pat(vecs[i].pat);
      do_run(vecs[i].u, vecs[i].stop_at, vecs[i].nm, st, cy, fp);
      chk({vecs[i].nm, ".tbl_status"}, st, vecs[i].exp_st);
      chk({vecs[i].nm, ".tbl_cycles"}, cy, vecs[i].exp_cyc);
      chk({vecs[i].nm, ".tbl_pc"},     fp, vecs[i].exp_pc);
    end

    // Asynchronous reset during RUN cycle 7, then a clean rerun.
    fill_pat(1);
    start_and_reset_phase(0, "midrst");
    for (int k = 0; k < 7; k++) begin
      pc_s[0] = 16'(pcq[k]);
      step();
    end
    chk("midrst.cycles7", cycles_s[0], 7);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals(0, "midrst");
    for (int i = 0; i < 2; i++) begin
      step();
      chk("midrst.no_done", done_s[0], 0);
    end
    reset = 1'b1;
    step();
    fill_pat(0);
    do_run(0, 0, "after_rst", st, cy, fp);
    chk("after_rst.status", st, 1);
    chk("after_rst.cycles", cy, 16);

    for (int r = 0; r < 8; r++) begin
      int u, sa;
      u = r % 2;
      pcq.delete();
      for (int i = 0; i < 60; i++) pcq.push_back($urandom_range(0, 3) + 100 * (i % 3 == 0 ? 0 : 1));
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 60;
      do_run(u, sa, $sformatf("rand%0d", r), st, cy, fp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
